pwm_regbank: RTL
================

# pwm_regbank

Parametrised multi-channel successor to the single-channel PWM register block. Holds CTRL/STATUS and period, prescaler and N duty registers as CPU-visible shadow copies, and drives separate active copies to the PWM core. When preload is enabled, shadow-to-active transfer happens only on a core update event (counter wrap) or a software-forced update. Sits between the bus-side register interface and the PWM counter/compare core; adds a registered read path, sticky status and an interrupt line.

## Interface
- WIDTH, 16, data/counter width (≥8)
- NCH, 4, number of compare channels (1..12)
- AW, 4, word-address width; map must fit (4+NCH ≤ 2^AW)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe, one word per cycle
- rd_en  in  1  read strobe
- addr  in  AW  word address
- wr_data  in  WIDTH  write data
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  high one cycle after an accepted read
- upd_evt  in  1  one-cycle pulse from core at counter wrap
- en  out  1  active enable
- mode  out  1  active mode (0 edge, 1 centre)
- period  out  WIDTH  active period
- prescaler_div  out  WIDTH  active prescaler
- duty  out  NCH*WIDTH  active duties, channel k at [k*WIDTH +: WIDTH]
- irq  out  1  STATUS.UIF & CTRL.UIE

## Operation
- Map: 0x0 CTRL, 0x1 STATUS, 0x2 PERIOD, 0x3 PRESC, 0x4+k DUTY[k]; others unmapped.
- CTRL: b0 EN, b1 MODE, b2 PRE (preload enable), b3 FUG (force update, write-only, reads 0), b4 UIE. EN/MODE/UIE take effect immediately, never shadowed.
- Writes to PERIOD/PRESC/DUTY update the shadow only.
- PRE=0: active copies the written shadow value on the same edge as the write.
- PRE=1: all active PERIOD/PRESC/DUTY load from shadow together on an edge where upd_evt=1 or FUG is written 1; otherwise hold.
- STATUS: b0 UIF (set on every upd_evt, also with PRE=0), b1 PEND (set by shadow write while PRE=1, cleared by transfer), b2 AERR (sticky, set by write/read to unmapped address). UIF and AERR are W1C; PEND read-only.
- Set beats clear: upd_evt with W1C of UIF in the same cycle leaves UIF=1.
- Shadow write coincident with transfer: active receives the pre-write shadow; new value stays in shadow; PEND stays 1.
- Clearing PRE while PEND=1 does not transfer; pending values wait for next upd_evt/FUG or a new write.
- Reads return shadow (not active) values; unmapped read returns 0 and sets AERR.
- wr_en and rd_en same cycle, same address: read returns the value before the write.

## Timing
- Reset: all shadow, active, STATUS, CTRL = 0; rd_data=0, rd_valid=0, irq=0, all outputs 0.
- Write: sampled at edge N; shadow and (PRE=0) active outputs change after edge N.
- Transfer: upd_evt high at edge N -> outputs change after edge N (zero-latency register, combinational only through flops).
- Read: rd_en at edge N -> rd_data/rd_valid valid after edge N for one cycle; rd_data holds last value when rd_valid=0.
- irq is combinational from flops, rises the cycle after the setting edge.
- Reset asserted mid-operation overrides all same-cycle writes and events.

## Structure
- Shared package pwm_pkg: address constants (ADDR_CTRL…ADDR_DUTY0), CTRL/STATUS bit indices, reset values.
- One natural sub-module: pwm_shadow_reg (one WIDTH-bit shadow/active pair with write, transfer, PRE inputs), instantiated 2+NCH times.

## Test plan
- Reset then read all mapped addresses -> every rd_data 0, irq 0, outputs 0.
- PRE=0, write PERIOD=0x0100 -> period=0x0100 next cycle; read PERIOD after write -> 0x0100, rd_valid one cycle.
- PRE=1, write DUTY[2]=0x0040 -> duty[2] unchanged, PEND=1; pulse upd_evt -> duty[2]=0x0040, PEND=0, UIF=1, irq=1 if UIE.
- PRE=1, write DUTY[0]=0x0010 same cycle as upd_evt (prior shadow 0x0008) -> active 0x0008, PEND=1; next upd_evt -> 0x0010.
- UIF W1C coincident with upd_evt -> UIF stays 1; lone W1C -> UIF 0, irq 0.
- Write/read addr 0xF (NCH=4) -> no state change, rd_data 0, AERR=1; FUG write with PRE=1 transfers all pending shadows.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM register bank: word map, CTRL/STATUS bit
// positions and reset values.
package pwm_pkg;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_STATUS = 1;
  localparam int unsigned ADDR_PERIOD = 2;
  localparam int unsigned ADDR_PRESC  = 3;
  localparam int unsigned ADDR_DUTY0  = 4;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_MODE = 1;
  localparam int unsigned CTRL_PRE  = 2;
  localparam int unsigned CTRL_FUG  = 3;
  localparam int unsigned CTRL_UIE  = 4;

  localparam int unsigned STATUS_UIF  = 0;
  localparam int unsigned STATUS_PEND = 1;
  localparam int unsigned STATUS_AERR = 2;

  localparam logic [4:0] CTRL_RST   = '0;
  localparam logic [2:0] STATUS_RST = '0;

endpackage

// File: rtl/pwm_regbank_if.sv
// Bus-side register access port of the PWM register bank.
interface pwm_regbank_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) ();
  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;

  modport master (output wr_en, rd_en, addr, wr_data, input rd_data, rd_valid);
  modport slave  (input wr_en, rd_en, addr, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/pwm_shadow_reg.sv
// One CPU-visible shadow register and the active copy driven to the PWM core.
module pwm_shadow_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pre,
  input  logic             xfer,
  output logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] active
);

  // A direct write (preload off) wins over a coincident transfer; a transfer
  // always moves the pre-write shadow value.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr)
        shadow <= wr_data;
      if (wr && !pre)
        active <= wr_data;
      else if (xfer)
        active <= shadow;
    end
  end

endmodule

// File: rtl/pwm_regbank.sv
// Multi-channel PWM register bank: shadow/active period, prescaler and duty
// registers with preload, sticky status, registered read path and interrupt.
module pwm_regbank
  import pwm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  pwm_regbank_if.slave       bus,
  input  logic               upd_evt,
  output logic               en,
  output logic               mode,
  output logic [WIDTH-1:0]   period,
  output logic [WIDTH-1:0]   prescaler_div,
  output logic [NCH*WIDTH-1:0] duty,
  output logic               irq
);

  localparam int NREG = 2 + NCH;

  logic ctrl_en, ctrl_mode, ctrl_pre, ctrl_uie;
  logic st_uif, st_pend, st_aerr;
  logic mapped, wr_ctrl, wr_status, fug, xfer, shadow_wr;
  logic [NREG-1:0]  reg_wr;
  logic [WIDTH-1:0] shadow [NREG];
  logic [WIDTH-1:0] active [NREG];
  logic [WIDTH-1:0] rd_next;

  assign mapped    = 32'(bus.addr) < 32'(ADDR_DUTY0) + 32'(NCH);
  assign wr_ctrl   = bus.wr_en && (bus.addr == AW'(ADDR_CTRL));
  assign wr_status = bus.wr_en && (bus.addr == AW'(ADDR_STATUS));
  assign fug       = wr_ctrl && bus.wr_data[CTRL_FUG];
  assign xfer      = upd_evt || fug;
  assign shadow_wr = |reg_wr;

  // Register i lives at ADDR_PERIOD+i: 0 period, 1 prescaler, 2.. duties.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign reg_wr[i] = bus.wr_en && (bus.addr == AW'(ADDR_PERIOD + i));
    pwm_shadow_reg #(.WIDTH(WIDTH)) u_reg (
      .clk     (clk),
      .rst     (rst),
      .wr      (reg_wr[i]),
      .wr_data (bus.wr_data),
      .pre     (ctrl_pre),
      .xfer    (xfer),
      .shadow  (shadow[i]),
      .active  (active[i])
    );
  end

  for (genvar k = 0; k < NCH; k++) begin : g_duty
    assign duty[k*WIDTH +: WIDTH] = active[2+k];
  end

  assign period        = active[0];
  assign prescaler_div = active[1];
  assign en            = ctrl_en;
  assign mode          = ctrl_mode;
  assign irq           = st_uif & ctrl_uie;

  // Later assignments take priority: set beats W1C, a write in preload
  // keeps PEND high even when a transfer happens on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      {ctrl_uie, ctrl_pre, ctrl_mode, ctrl_en} <= {CTRL_RST[CTRL_UIE], CTRL_RST[CTRL_PRE],
                                                  CTRL_RST[CTRL_MODE], CTRL_RST[CTRL_EN]};
      {st_aerr, st_pend, st_uif} <= STATUS_RST;
    end else begin
      if (wr_ctrl) begin
        ctrl_en   <= bus.wr_data[CTRL_EN];
        ctrl_mode <= bus.wr_data[CTRL_MODE];
        ctrl_pre  <= bus.wr_data[CTRL_PRE];
        ctrl_uie  <= bus.wr_data[CTRL_UIE];
      end
      if (wr_status && bus.wr_data[STATUS_UIF])
        st_uif <= 1'b0;
      if (wr_status && bus.wr_data[STATUS_AERR])
        st_aerr <= 1'b0;
      if (upd_evt)
        st_uif <= 1'b1;
      if ((bus.wr_en || bus.rd_en) && !mapped)
        st_aerr <= 1'b1;
      if (xfer)
        st_pend <= 1'b0;
      if (shadow_wr && ctrl_pre)
        st_pend <= 1'b1;
    end
  end

  always_comb begin
    rd_next = '0;
    if (bus.addr == AW'(ADDR_CTRL)) begin
      rd_next[CTRL_EN]   = ctrl_en;
      rd_next[CTRL_MODE] = ctrl_mode;
      rd_next[CTRL_PRE]  = ctrl_pre;
      rd_next[CTRL_UIE]  = ctrl_uie;
    end else if (bus.addr == AW'(ADDR_STATUS)) begin
      rd_next[STATUS_UIF]  = st_uif;
      rd_next[STATUS_PEND] = st_pend;
      rd_next[STATUS_AERR] = st_aerr;
    end
    for (int unsigned i = 0; i < NREG; i++)
      if (bus.addr == AW'(ADDR_PERIOD + i))
        rd_next = shadow[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en)
        bus.rd_data <= rd_next;
    end
  end

endmodule
